// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
//   state_t      : FSM state encoding (ST_IDLE = 0, ST_GRANT = 1)
//   HOLD_MAX_DEF : default hold timeout in cycles (0 disables the timeout)
package rr_arbiter4_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int HOLD_MAX_DEF = 16;

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the arbiter.
//   req[3:0]     : request lines, req[i] high while requester i wants the resource
//   done         : release strobe from the current owner
//   gnt[3:0]     : one-hot grant, zero when idle
//   gnt_idx[1:0] : index of the current or last owner
//   busy         : a grant is active
//   timeout      : one-cycle pulse after a forced release by the hold timer
// slave  = arbiter side, master = requester side.
interface rr_arbiter4_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout;

    modport master (output req, done, input gnt, gnt_idx, busy, timeout);
    modport slave  (input req, done, output gnt, gnt_idx, busy, timeout);
endinterface

// File: rtl/rr_arbiter4_dec.sv
// 2-to-4 line decoder. a is the MSB, b the LSB of the select index.
//   a, b   : select inputs
//   y0..y3 : one-hot outputs, y[k] high when {a,b} == k
module decoder2_4 (
    input  logic a,
    input  logic b,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3
);
    assign y0 = ~a & ~b;
    assign y1 = ~a &  b;
    assign y2 =  a & ~b;
    assign y3 =  a &  b;
endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters with an optional hold timeout.
// A grant is held until done, until the owner drops its request, or until
// the hold counter expires; the next scan then starts just past the owner.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : rr_arbiter4_if.slave (req/done in, gnt/gnt_idx/busy/timeout out)
// Parameters: HOLD_MAX (0 disables timeout), CNT_W (2^CNT_W > HOLD_MAX).
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF,
    parameter int CNT_W    = 5
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter4_if.slave  bus
);

    // Last count value before a forced release; unused when HOLD_MAX == 0.
    localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic             hold_exp;
    logic [3:0]       dec_y;

    // First set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). The loop
    // runs from the farthest slot down so the nearest hit is written last.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        to_d     = 1'b0;
        hold_exp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    idx_d   = rr_pick(bus.req, ptr_q);
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                hold_exp = (HOLD_MAX != 0) && (cnt_q == CNT_LAST);
                if (bus.done || !bus.req[idx_q] || hold_exp) begin
                    state_d = ST_IDLE;
                    ptr_d   = idx_q + 2'd1;
                    // Only a forced release flags timeout; done or a dropped
                    // request in the same cycle takes precedence.
                    to_d    = hold_exp && !bus.done && bus.req[idx_q];
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    decoder2_4 u_dec (
        .a  (idx_q[1]),
        .b  (idx_q[0]),
        .y0 (dec_y[0]),
        .y1 (dec_y[1]),
        .y2 (dec_y[2]),
        .y3 (dec_y[3])
    );

    assign bus.busy    = (state_q == ST_GRANT);
    assign bus.gnt     = dec_y & {4{bus.busy}};
    assign bus.gnt_idx = idx_q;
    assign bus.timeout = to_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    rr_arbiter4_if bus();

    rr_arbiter4 #(.HOLD_MAX(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [1:0] i;
        logic       b;
        logic       t;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Monitor: outputs are Moore, so each queued entry is the expected
    // state during the cycle its stimulus was applied; sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({bus.gnt, bus.gnt_idx, bus.busy, bus.timeout} !== {e.g, e.i, e.b, e.t}) begin
                    n_err++;
                    $display("FAIL %s: got gnt=%b idx=%0d busy=%b to=%b, want gnt=%b idx=%0d busy=%b to=%b",
                             e.name, bus.gnt, bus.gnt_idx, bus.busy, bus.timeout, e.g, e.i, e.b, e.t);
                end
            end
        end
    end

    // Apply inputs for one cycle and queue the outputs expected in it.
    task automatic step(input logic [3:0] r, input logic d, input logic [3:0] g,
                        input logic [1:0] i, input logic b, input logic t, input string name);
        exp_t e;
        bus.req  = r;
        bus.done = d;
        e.g = g; e.i = i; e.b = b; e.t = t; e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // idle after reset
        for (int k = 0; k < 5; k++) step(4'b0000, 0, 4'b0000, 2'd0, 0, 0, "reset_idle");

        // full rotation with done one cycle after each grant
        step(4'b1111, 0, 4'b0000, 2'd0, 0, 0, "rot_idle0");
        step(4'b1111, 1, 4'b0001, 2'd0, 1, 0, "rot_g0");
        step(4'b1111, 0, 4'b0000, 2'd0, 0, 0, "rot_gap0");
        step(4'b1111, 1, 4'b0010, 2'd1, 1, 0, "rot_g1");
        step(4'b1111, 0, 4'b0000, 2'd1, 0, 0, "rot_gap1");
        step(4'b1111, 1, 4'b0100, 2'd2, 1, 0, "rot_g2");
        step(4'b1111, 0, 4'b0000, 2'd2, 0, 0, "rot_gap2");
        step(4'b1111, 1, 4'b1000, 2'd3, 1, 0, "rot_g3");
        step(4'b1111, 0, 4'b0000, 2'd3, 0, 0, "rot_gap3");
        step(4'b1111, 1, 4'b0001, 2'd0, 1, 0, "rot_g0_again");
        step(4'b0000, 0, 4'b0000, 2'd0, 0, 0, "rot_end");

        // owner 1 releases (ptr=2), then req=0011 wraps to 0
        step(4'b0010, 0, 4'b0000, 2'd0, 0, 0, "wrap_idle");
        step(4'b0010, 1, 4'b0010, 2'd1, 1, 0, "wrap_g1");
        step(4'b0011, 0, 4'b0000, 2'd1, 0, 0, "wrap_gap");
        step(4'b0011, 1, 4'b0001, 2'd0, 1, 0, "wrap_g0");
        step(4'b0000, 0, 4'b0000, 2'd0, 0, 0, "wrap_end");

        // hold timeout: busy exactly 4 cycles, timeout pulse, re-grant
        step(4'b0100, 0, 4'b0000, 2'd0, 0, 0, "to_idle");
        for (int k = 0; k < 4; k++) step(4'b0100, 0, 4'b0100, 2'd2, 1, 0, "to_hold");
        step(4'b0100, 0, 4'b0000, 2'd2, 0, 1, "to_pulse");
        step(4'b0100, 1, 4'b0100, 2'd2, 1, 0, "to_regrant");
        step(4'b0000, 0, 4'b0000, 2'd2, 0, 0, "to_end");

        // done coinciding with the last hold cycle: no timeout pulse
        step(4'b0100, 0, 4'b0000, 2'd2, 0, 0, "dt_idle");
        for (int k = 0; k < 3; k++) step(4'b0100, 0, 4'b0100, 2'd2, 1, 0, "dt_hold");
        step(4'b0100, 1, 4'b0100, 2'd2, 1, 0, "dt_done_last");
        step(4'b0000, 0, 4'b0000, 2'd2, 0, 0, "dt_no_timeout");

        // owner 1 drops its request; ptr=2 confirmed by next scan choosing 0
        step(4'b0010, 0, 4'b0000, 2'd2, 0, 0, "drop_idle");
        step(4'b0000, 0, 4'b0010, 2'd1, 1, 0, "drop_g1");
        step(4'b0011, 0, 4'b0000, 2'd1, 0, 0, "drop_released");
        step(4'b0011, 1, 4'b0001, 2'd0, 1, 0, "drop_ptr2_pick0");
        step(4'b0000, 0, 4'b0000, 2'd0, 0, 0, "drop_end");

        // done while idle is ignored; requests during a grant are ignored
        step(4'b0000, 1, 4'b0000, 2'd0, 0, 0, "idle_done");
        step(4'b0000, 0, 4'b0000, 2'd0, 0, 0, "idle_done_after");
        step(4'b0001, 0, 4'b0000, 2'd0, 0, 0, "ign_idle");
        step(4'b1111, 0, 4'b0001, 2'd0, 1, 0, "ign_hold");
        step(4'b1111, 1, 4'b0001, 2'd0, 1, 0, "ign_done");
        step(4'b0000, 0, 4'b0000, 2'd0, 0, 0, "ign_end");

        // reset between edges during a grant
        step(4'b1000, 0, 4'b0000, 2'd0, 0, 0, "rst_idle");
        step(4'b1000, 0, 4'b1000, 2'd3, 1, 0, "rst_g3");
        rst = 1'b1;
        step(4'b1000, 0, 4'b0000, 2'd0, 0, 0, "rst_async");
        rst = 1'b0;
        step(4'b1000, 0, 4'b0000, 2'd0, 0, 0, "rst_after");
        step(4'b1000, 1, 4'b1000, 2'd3, 1, 0, "rst_regrant3");
        step(4'b0000, 0, 4'b0000, 2'd3, 0, 0, "rst_end");

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Round-robin arbiter that shares one resource among four requesters. It issues a one-hot grant by driving a registered 2-bit winner index through the team's 2-to-4 decoder. A grant is held until the owner signals completion, the owner drops its request, or a hold timeout expires. The block sits in front of any shared 4-way resource, such as a bus port or a result register.

## Interface
Parameters:
- HOLD_MAX, default 16: maximum number of cycles a grant may be held. 0 disables the timeout.
- CNT_W, default 5: hold counter width. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  : the single clock; all state updates on its rising edge.
- rst  input  1  : asynchronous, active-high reset.
- req  input  4  : request lines. req[i] is high while requester i wants the resource.
- done  input  1  : release strobe from the current owner. Valid only while busy is high.
- gnt  output  4  : one-hot grant. All zero when idle.
- gnt_idx  output  2  : index of the current or last owner.
- busy  output  1  : a grant is active.
- timeout  output  1  : one-cycle pulse when a grant is forcibly released by the hold timeout.

## Operation
States:
- IDLE: busy=0, gnt=0.
- GRANT: busy=1, gnt one-hot on gnt_idx.

IDLE behaviour:
- If req != 0, choose the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- Load that index into gnt_idx, clear the hold counter, go to GRANT.
- If req == 0, stay in IDLE. ptr and gnt_idx are unchanged.

GRANT behaviour: release when any of these holds:
- done is high.
- req[gnt_idx] is low.
- HOLD_MAX != 0 and the counter reaches HOLD_MAX-1. In this case only, timeout pulses.

On release:
- ptr <= gnt_idx + 1, wrapping 3 -> 0.
- Go to IDLE.

While GRANT is held, the counter increments each cycle. It saturates and never wraps.

Decoding: gnt = decoder outputs {y3,y2,y1,y0} ANDed with busy. Decoder input a = gnt_idx[1], b = gnt_idx[0].

Reset values: gnt=0, gnt_idx=0, busy=0, timeout=0, ptr=0, counter=0, state IDLE.

Boundary conditions:
- Simultaneous done and timeout: treat as a done release. timeout stays 0.
- Requests arriving in GRANT: ignored until the block returns to IDLE.
- A single persistent requester: it is re-granted after each one-cycle IDLE gap.
- done while in IDLE: ignored.

## Timing
- Grant latency: req sampled at edge N in IDLE -> gnt/busy high after edge N. One cycle from request to grant.
- Release: condition true at edge M -> gnt/busy low after edge M. Minimum one IDLE cycle between consecutive grants.
- Arbitration throughput: at most one grant per 2 cycles.
- Timeout: with HOLD_MAX=H, busy is high for exactly H cycles, then timeout is high for the first IDLE cycle.
- Reset mid-grant: all outputs drop asynchronously. ptr returns to 0.

## Structure
- Shared include/package `arb_defs`: state encodings ST_IDLE=1'b0, ST_GRANT=1'b1, and the default HOLD_MAX.
- Sub-module: one instance of the existing `decoder2_4` (ports a, b, y0..y3) produces the one-hot grant.
- The rotating priority scan is a combinational function inside `rr_arbiter4`.
- State, ptr, gnt_idx and the counter are registered in one always block with asynchronous reset.

## Test plan
- Reset, then req=4'b0000 for 5 cycles -> gnt=0, busy=0, gnt_idx=0 throughout.
- req=4'b1111 held, done pulsed one cycle after each grant -> grant order 0001, 0010, 0100, 1000, 0001, with a one-cycle gap between grants.
- ptr=2 (after owner 1 releases), req=4'b0011 -> gnt=0001 (wrap: scan 2, 3, 0).
- HOLD_MAX=4, req=4'b0100 held, done=0 -> busy high 4 cycles, then timeout pulses once and gnt=0; re-grant 0100 one cycle later.
- Grant to 1 with req=4'b0010, then drop req[1] -> gnt=0 after next edge, ptr=2, timeout=0.
- rst asserted mid-grant between edges -> gnt, busy, gnt_idx go to 0 immediately; after deassert, req=4'b1000 -> gnt=1000.
